wb_dmem_slave: RTL and testbench
================================

WB_DMEM_SLAVE -- requirements
Module: wb_dmem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the memory size in 32-bit words; it SHALL be a power of two.
REQ-002 SHALL have parameter WAIT_STATES, default 1, the number of idle cycles inserted before ack/err; the legal range is 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0; it SHALL be aligned to DEPTH*4.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 wbs_cyc_i  in  1  bus cycle active.
REQ-007 wbs_stb_i  in  1  strobe; request valid.
REQ-008 wbs_we_i  in  1  1 = write, 0 = read.
REQ-009 wbs_sel_i  in  4  byte-lane enables; bit n covers dat[8n+7:8n].
REQ-010 wbs_addr_i  in  32  byte address; bits [1:0] are ignored.
REQ-011 wbs_dat_i  in  32  write data.
REQ-012 wbs_dat_o  out  32  read data; valid only while wbs_ack_o=1, otherwise 0.
REQ-013 wbs_ack_o  out  1  one-cycle transfer-complete pulse.
REQ-014 wbs_err_o  out  1  one-cycle error-termination pulse.

Function
REQ-015 FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE -> WAIT when cyc_i & stb_i and WAIT_STATES>0.
- IDLE -> RESP when cyc_i & stb_i and WAIT_STATES=0.
REQ-016 On leaving IDLE, addr/we/sel/dat_i SHALL be captured; later changes to those inputs SHALL be ignored for that transfer.
REQ-017 WAIT SHALL count WAIT_STATES cycles, then go to RESP.
REQ-018 RESP SHALL last exactly one cycle, with ack_o=1 (valid access) or err_o=1 (invalid access); ack_o and err_o SHALL never both be 1.
REQ-019 RESP -> HOLD; HOLD -> IDLE once stb_i=0 or cyc_i=0, so a still-asserted stb_i is not taken as a new request.
REQ-020 Latency from stb_i sampled high to ack_o SHALL be WAIT_STATES+1 cycles.
REQ-021 Writes SHALL update only the bytes enabled by sel, on the RESP clock edge; sel=4'b0000 SHALL complete with ack and change no memory.
REQ-022 Reads SHALL return the full 32-bit word on dat_o during RESP, regardless of sel.
REQ-023 If cyc_i or stb_i drops while in WAIT (abort), the FSM SHALL return to IDLE with no memory write and no ack/err.
REQ-024 A word index of DEPTH-1 SHALL be legal; DEPTH and above is handled per REQ-029/REQ-030.

Reset
REQ-025 Asserting rst_ni=0 SHALL immediately force: state IDLE, wait counter 0, ack_o=0, err_o=0, dat_o=0.
REQ-026 Reset in mid-transfer SHALL abort the transfer: no write and no response.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Deassertion of rst_ni SHALL be synchronized to clk_i; the first request SHALL be sampled on the first rising edge after the synchronizer releases.

Configuration
REQ-029 With WB_DMEM_ERR_EN defined: an address outside [BASE_ADDR, BASE_ADDR+DEPTH*4) SHALL terminate with err_o=1 in RESP, after the same latency as REQ-020, with no write and dat_o=0.
REQ-030 Without WB_DMEM_ERR_EN: wbs_err_o SHALL be tied 0, and addresses SHALL wrap modulo DEPTH*4 onto the memory.

Verification
REQ-031 WAIT_STATES=1: write 32'hDEADBEEF, sel=4'hF, to 0x10, then read 0x10 -> ack two cycles after each stb; read returns 32'hDEADBEEF.
REQ-032 Pre-load 0x20 with 32'h11223344; write 32'hAABBCCDD with sel=4'b0101; read 0x20 -> 32'h11BB33DD.
REQ-033 WAIT_STATES=3: stb held high for 2 cycles, then dropped -> no ack, memory unchanged, FSM back in IDLE.
REQ-034 WB_DMEM_ERR_EN defined, DEPTH=1024: read 0x1000 -> err_o pulse, ack_o=0, dat_o=0. Macro undefined: same read returns word 0.
REQ-035 rst_ni pulled low during WAIT of a write to 0x8 -> no ack, word 0x8 unchanged, all outputs 0.
REQ-036 stb held high after ack -> exactly one ack, then no further response until stb drops and rises again.

Source files
------------

// File: rtl/wb_dmem_slave_if.sv
// Wishbone slave bus bundle for wb_dmem_slave.
// Signal names keep the original port names so existing hookups map one-to-one.
`timescale 1ns/1ps
interface wb_dmem_slave_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_dmem_slave.sv
// Wishbone data-memory slave: DEPTH x 32-bit words, byte-lane writes,
// WAIT_STATES idle cycles before the single-cycle ack/err response.
// Optional feature: define WB_DMEM_ERR_EN to terminate accesses outside
// [BASE_ADDR, BASE_ADDR+DEPTH*4) with err; otherwise addresses wrap.
`timescale 1ns/1ps
module wb_dmem_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wb_dmem_slave_if.slave  wbs
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_rst_sync;
  logic [3:0]      r_wcnt, w_wcnt_nxt;
  logic [AW-1:0]   r_idx;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [31:0]     r_dat;
  logic            r_bad;
  logic            w_req;
  logic            w_capture;
  logic            w_bad;
  logic            w_ok;
  logic            w_mem_we;
  logic            w_unused;
  logic [31:0]     r_mem [DEPTH];

  assign w_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_unused = &{1'b0, wbs.wbs_addr_i[1:0], wbs.wbs_addr_i[31:AW+2]};

`ifdef WB_DMEM_ERR_EN
  // BASE_ADDR is aligned to DEPTH*4, so an in-range address matches it above the index bits
  assign w_bad = (wbs.wbs_addr_i[31:AW+2] != BASE_ADDR[31:AW+2]);
  assign w_ok  = ~r_bad;
`else
  assign w_bad = 1'b0;
  assign w_ok  = 1'b1;
`endif

  // Reset synchronizer: assert immediately, release two clock edges later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // State and wait counter; held in IDLE until the synchronized reset releases
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else if (!r_rst_sync[1]) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Request capture when leaving IDLE; later bus changes do not affect the transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_dat <= '0;
      r_bad <= 1'b0;
    end else if (w_capture) begin
      r_idx <= wbs.wbs_addr_i[AW+1:2];
      r_we  <= wbs.wbs_we_i;
      r_sel <= wbs.wbs_sel_i;
      r_dat <= wbs.wbs_dat_i;
      r_bad <= w_bad;
    end
  end

  // Next-state logic and bus outputs (outputs depend on state only)
  always_comb begin
    w_state_nxt    = r_state;
    w_wcnt_nxt     = r_wcnt;
    w_capture      = 1'b0;
    w_mem_we       = 1'b0;
    wbs.wbs_ack_o  = 1'b0;
    wbs.wbs_err_o  = 1'b0;
    wbs.wbs_dat_o  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_capture   = 1'b1;
          w_wcnt_nxt  = '0;
          w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WS_LAST) begin
          w_state_nxt = S_RESP;
          w_wcnt_nxt  = '0;
        end else begin
          w_wcnt_nxt  = r_wcnt + 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt   = S_HOLD;
        wbs.wbs_ack_o = w_ok;
        wbs.wbs_err_o = ~w_ok;
        w_mem_we      = w_ok & r_we;
        if (w_ok && !r_we) wbs.wbs_dat_o = r_mem[r_idx];
      end
      S_HOLD: begin
        if (!w_req) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte-lane write on the RESP edge; memory is never cleared by reset
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_dmem_slave.sv
// Randomized self-checking bench for wb_dmem_slave against a word-array model.
`timescale 1ns/1ps
module tb_wb_dmem_slave;

`ifdef WB_DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] ref_a [1024];

  wb_dmem_slave_if bus_a ();
  wb_dmem_slave_if bus_b ();

  wb_dmem_slave #(.DEPTH(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wbs(bus_a)
  );

  wb_dmem_slave #(.DEPTH(64), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wbs(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic c, input logic s, input logic we,
                       input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      bus_a.wbs_cyc_i = c; bus_a.wbs_stb_i = s; bus_a.wbs_we_i = we;
      bus_a.wbs_sel_i = sel; bus_a.wbs_addr_i = a; bus_a.wbs_dat_i = d;
    end else begin
      bus_b.wbs_cyc_i = c; bus_b.wbs_stb_i = s; bus_b.wbs_we_i = we;
      bus_b.wbs_sel_i = sel; bus_b.wbs_addr_i = a; bus_b.wbs_dat_i = d;
    end
  endtask

  task automatic sample(input int w, output logic ack, output logic err, output logic [31:0] dat);
    if (w == 0) begin
      ack = bus_a.wbs_ack_o; err = bus_a.wbs_err_o; dat = bus_a.wbs_dat_o;
    end else begin
      ack = bus_b.wbs_ack_o; err = bus_b.wbs_err_o; dat = bus_b.wbs_dat_o;
    end
  endtask

  // One transfer; after the first edge the request fields are scrambled while
  // cyc/stb stay high, so only the captured values may matter.
  task automatic xfer(input int w, input logic we, input logic [31:0] a, input logic [3:0] sel,
                      input logic [31:0] d, output logic ack, output logic err,
                      output logic [31:0] rd, output int lat);
    logic        s_ack, s_err;
    logic [31:0] q;
    ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
    @(posedge clk); #1;
    drive(w, 1'b1, 1'b1, we, sel, a, d);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      sample(w, s_ack, s_err, q);
      chk("ack_err_excl", 32'(s_ack & s_err), 32'd0);
      if (s_ack || s_err) begin
        ack = s_ack; err = s_err; rd = q; lat = i;
        break;
      end
      chk("dat_idle", q, 32'd0);
      if (i == 1) drive(w, 1'b1, 1'b1, ~we, 4'($urandom), $urandom, $urandom);
    end
    chk("response_seen", 32'(lat != 0), 32'd1);
    drive(w, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_a(input logic we, input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic        ack, err, exp_err;
    logic [31:0] rd;
    int          lat;
    int unsigned idx;
    xfer(0, we, a, sel, d, ack, err, rd, lat);
    exp_err = ERR_EN && (a >= 32'h0000_1000);
    idx     = (a / 4) % 1024;
    chk("a_latency", 32'(lat), 32'd2);
    chk("a_ack", 32'(ack), 32'(!exp_err));
    chk("a_err", 32'(err), 32'(exp_err));
    if (!we) chk("a_rdata", rd, exp_err ? 32'd0 : ref_a[idx]);
    else if (!exp_err) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_a[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k   = $urandom_range(0, 23);
    logic [9:0]  idx = (k < 16) ? 10'(k) : 10'(1000 + k);
    logic [19:0] hi  = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'd0;
    logic [1:0]  lo  = 2'($urandom);
    return {hi, idx, lo};
  endfunction

  initial begin
    logic        ack, err, s_ack, s_err;
    logic [31:0] rd, q;
    int          lat, acks;

    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    sample(0, s_ack, s_err, q);
    chk("rst_ack", 32'(s_ack), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    chk("rst_dat", q, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Known contents for the words the random phase uses
    for (int k = 0; k < 24; k++)
      do_a(1'b1, 32'((k < 16 ? k : 1000 + k) * 4), 4'hF, $urandom);

    // Full-word write then read back
    do_a(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    do_a(1'b0, 32'h10, 4'hF, 32'h0);
    chk("dir_deadbeef", ref_a[4], 32'hDEAD_BEEF);

    // Partial write over a preloaded word
    do_a(1'b1, 32'h20, 4'hF, 32'h1122_3344);
    do_a(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
    xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, ack, err, rd, lat);
    chk("dir_partial", rd, 32'h11BB_33DD);

    // sel=0 write acks and changes nothing; read ignores sel
    do_a(1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
    do_a(1'b0, 32'h20, 4'h1, 32'h0);

    // Top word, and first address past the end
    do_a(1'b1, 32'hFFC, 4'hF, 32'h0BAD_CAFE);
    do_a(1'b0, 32'hFFC, 4'hF, 32'h0);
    do_a(1'b0, 32'h1000, 4'hF, 32'h0);
    do_a(1'b1, 32'h1000, 4'hF, 32'h1234_5678);
    do_a(1'b0, 32'h0, 4'hF, 32'h0);

    // Random traffic
    for (int n = 0; n < 150; n++)
      do_a(1'($urandom), rand_addr(), 4'($urandom), $urandom);

    // stb held high after ack: exactly one response, then a fresh request works
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sample(0, s_ack, s_err, q);
      if (s_ack || s_err) acks++;
    end
    chk("held_stb_acks", 32'(acks), 32'd1);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    do_a(1'b0, 32'h10, 4'hF, 32'h0);

    // Reset during WAIT of a write to 0x8
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h8, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sample(0, s_ack, s_err, q);
    chk("midrst_ack", 32'(s_ack), 32'd0);
    chk("midrst_err", 32'(s_err), 32'd0);
    chk("midrst_dat", q, 32'd0);
    @(posedge clk); #1;
    sample(0, s_ack, s_err, q);
    chk("midrst_ack2", 32'(s_ack), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_a(1'b0, 32'h8, 4'hF, 32'h0);

    // Second instance, WAIT_STATES=3: abort after two WAIT cycles
    xfer(1, 1'b1, 32'h1040, 4'hF, 32'h5A5A_5A5A, ack, err, rd, lat);
    chk("b_wr_latency", 32'(lat), 32'd4);
    chk("b_wr_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h1040, 32'hFFFF_FFFF);
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sample(1, s_ack, s_err, q);
      if (s_ack || s_err) acks++;
    end
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sample(1, s_ack, s_err, q);
      if (s_ack || s_err) acks++;
    end
    chk("b_abort_resp", 32'(acks), 32'd0);
    xfer(1, 1'b0, 32'h1040, 4'hF, 32'h0, ack, err, rd, lat);
    chk("b_rd_latency", 32'(lat), 32'd4);
    chk("b_rd_ack", 32'(ack), 32'd1);
    chk("b_rd_data", rd, 32'h5A5A_5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
